// File: rtl/mem_port_arbiter_if.sv
// Bundle of every handshake and bus signal around mem_port_arbiter: the fetch
// port, the load/store port, the memory port and the sticky error flag.
interface mem_port_arbiter_if #(
    parameter int WIDTH = 32
);
    // Fetch (IF stage) port
    logic             if_req;
    logic [WIDTH-1:0] if_addr;
    logic             if_ack;
    logic [31:0]      if_rdata;

    // Load/store (MEM stage) port
    logic             d_req;
    logic             d_we;
    logic [WIDTH-1:0] d_addr;
    logic [31:0]      d_wdata;
    logic             d_ack;
    logic [31:0]      d_rdata;

    // Single-ported memory
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [31:0]      mem_wdata;
    logic             mem_ack;
    logic [31:0]      mem_rdata;

    // Sticky timeout indication
    logic             bus_err;

    // The arbiter's view: it answers the requesters and drives the memory.
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        output if_ack, if_rdata, d_ack, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, bus_err
    );

    // The surrounding pipeline and memory: they raise requests and answer mem_req.
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, bus_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store.
// One transaction is in flight at a time. Data accesses win by default, but
// no more than MAX_STREAK data grants in a row may pass a waiting fetch.
// A transaction that sees no mem_ack within TIMEOUT cycles is aborted.
// Completion returns zero data and sets the sticky bus_err flag.
module mem_port_arbiter #(
    parameter int WIDTH      = 32,
    parameter int MAX_STREAK = 2,
    parameter int TIMEOUT    = 16
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } state_t;

    localparam int SW = $clog2(MAX_STREAK + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);
    localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t           state_q,     state_d;
    logic [SW-1:0]    streak_q,    streak_d;
    logic [TW-1:0]    timer_q,     timer_d;
    logic             if_ack_q,    if_ack_d;
    logic [31:0]      if_rdata_q,  if_rdata_d;
    logic             d_ack_q,     d_ack_d;
    logic [31:0]      d_rdata_q,   d_rdata_d;
    logic             mem_req_q,   mem_req_d;
    logic             mem_we_q,    mem_we_d;
    logic [WIDTH-1:0] mem_addr_q,  mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic             bus_err_q,   bus_err_d;

    logic i_elig;
    logic d_elig;
    logic timed_out;

    // State register and every registered output; reset drops everything to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            timer_q     <= '0;
            if_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            d_ack_q     <= 1'b0;
            d_rdata_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            timer_q     <= timer_d;
            if_ack_q    <= if_ack_d;
            if_rdata_q  <= if_rdata_d;
            d_ack_q     <= d_ack_d;
            d_rdata_q   <= d_rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            bus_err_q   <= bus_err_d;
        end
    end

    // Grant selection in IDLE, completion/abort while serving, acks pulse for one cycle.
    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        timer_d     = timer_q;
        if_ack_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_ack_d     = 1'b0;
        d_rdata_d   = d_rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        bus_err_d   = bus_err_q;

        // A requester still holding req during its own ack cycle is finishing the
        // previous access, not asking for a new one.
        i_elig    = bus.if_req && !if_ack_q;
        d_elig    = bus.d_req && !d_ack_q;
        timed_out = (TIMEOUT != 0) && (timer_q == TIMER_LAST);

        case (state_q)
            IDLE: begin
                if (d_elig && (!bus.if_req || (streak_q < STREAK_MAX))) begin
                    state_d     = SERVE_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.d_we;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                    timer_d     = '0;
                    streak_d    = bus.if_req ? streak_q + SW'(1) : '0;
                end else if (i_elig) begin
                    state_d     = SERVE_I;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.if_addr;
                    mem_wdata_d = '0;
                    timer_d     = '0;
                    streak_d    = '0;
                end
            end

            SERVE_I, SERVE_D: begin
                if (bus.mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    if (state_q == SERVE_I) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = bus.mem_rdata;
                    end else begin
                        d_ack_d = 1'b1;
                        if (!mem_we_q) begin
                            d_rdata_d = bus.mem_rdata;
                        end
                    end
                end else if (timed_out) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    if (state_q == SERVE_I) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = '0;
                    end else begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = '0;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    assign bus.if_ack    = if_ack_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.bus_err   = bus_err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Inputs change and outputs are sampled
// on the falling clock edge, away from the rising edge where the DUT updates.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.WIDTH(32)) bus ();

    mem_port_arbiter #(
        .WIDTH(32),
        .MAX_STREAK(2),
        .TIMEOUT(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int checkCount = 0;
    int passCount  = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic ifReq, input logic [31:0] ifAddr,
                                 input logic dReq, input logic dWe,
                                 input logic [31:0] dAddr, input logic [31:0] dWdata);
        bus.if_req  = ifReq;
        bus.if_addr = ifAddr;
        bus.d_req   = dReq;
        bus.d_we    = dWe;
        bus.d_addr  = dAddr;
        bus.d_wdata = dWdata;
    endtask

    // Leaves the bench on the falling edge of the first cycle with mem_req high.
    task automatic waitMemReq(input string tag);
        for (int i = 0; i < 32 && bus.mem_req !== 1'b1; i++) begin
            step();
        end
        checkOutput({tag, "_mem_req"}, 64'(bus.mem_req), 64'd1);
    endtask

    // Answers after 'delay' extra mem_req cycles; returns on the cycle the ack is visible.
    task automatic memRespond(input int delay, input logic [31:0] rdata);
        repeat (delay) step();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rdata;
        step();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] grantAddr [6];
        int reqCycles;

        reset = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        step();
        step();

        // Reset state: everything zero
        checkOutput("rst_mem_req",  64'(bus.mem_req),   64'd0);
        checkOutput("rst_mem_we",   64'(bus.mem_we),    64'd0);
        checkOutput("rst_mem_addr", 64'(bus.mem_addr),  64'd0);
        checkOutput("rst_acks",     64'({bus.if_ack, bus.d_ack}), 64'd0);
        checkOutput("rst_if_rdata", 64'(bus.if_rdata),  64'd0);
        checkOutput("rst_d_rdata",  64'(bus.d_rdata),   64'd0);
        checkOutput("rst_bus_err",  64'(bus.bus_err),   64'd0);
        reset = 1'b0;
        step();

        // Fetch of 0x8, memory answers on the second mem_req cycle
        applyStimulus(1'b1, 32'h8, 1'b0, 1'b0, '0, '0);
        step();
        checkOutput("t1_req_latency", 64'(bus.mem_req),  64'd1);
        checkOutput("t1_mem_addr",    64'(bus.mem_addr), 64'h8);
        checkOutput("t1_mem_we",      64'(bus.mem_we),   64'd0);
        step();
        checkOutput("t1_no_early_ack", 64'(bus.if_ack), 64'd0);
        memRespond(0, 32'h0050_0093);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        checkOutput("t1_if_ack",   64'(bus.if_ack),   64'd1);
        checkOutput("t1_if_rdata", 64'(bus.if_rdata), 64'h0050_0093);
        checkOutput("t1_req_drop", 64'(bus.mem_req),  64'd0);
        step();
        checkOutput("t1_ack_pulse", 64'(bus.if_ack),  64'd0);

        // A stray mem_ack while idle changes nothing
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hFFFF_FFFF;
        step();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        checkOutput("idle_ack_acks",   64'({bus.if_ack, bus.d_ack}), 64'd0);
        checkOutput("idle_ack_rdata",  64'(bus.if_rdata), 64'h0050_0093);
        checkOutput("idle_ack_memreq", 64'(bus.mem_req),  64'd0);

        // Both held: each ack cycle hides its own requester, so the slot goes to
        // the other side and grants alternate starting with data.
        grantAddr = '{32'h200, 32'h100, 32'h200, 32'h100, 32'h200, 32'h100};
        applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'h200, '0);
        for (int k = 0; k < 6; k++) begin
            waitMemReq($sformatf("t2_g%0d", k));
            checkOutput($sformatf("t2_addr%0d", k), 64'(bus.mem_addr), 64'(grantAddr[k]));
            memRespond(0, 32'h1000 + 32'(k));
            if (k == 5) begin
                applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
            end
            checkOutput($sformatf("t2_ack%0d", k), 64'({bus.if_ack, bus.d_ack}),
                        (grantAddr[k] == 32'h200) ? 64'd1 : 64'd2);
        end
        checkOutput("t2_d_rdata",  64'(bus.d_rdata),  64'h1004);
        checkOutput("t2_if_rdata", 64'(bus.if_rdata), 64'h1005);
        step();

        // Fetch pending at two data grants in a row: the third slot must be the fetch.
        applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'h204, '0);
        waitMemReq("t2b_g0");
        checkOutput("t2b_addr0", 64'(bus.mem_addr), 64'h204);
        memRespond(0, 32'h2000);
        bus.if_req = 1'b0;
        step();
        checkOutput("t2b_gap0", 64'(bus.mem_req), 64'd0);
        bus.if_req = 1'b1;
        waitMemReq("t2b_g1");
        checkOutput("t2b_addr1", 64'(bus.mem_addr), 64'h204);
        memRespond(0, 32'h2001);
        bus.if_req = 1'b0;
        step();
        checkOutput("t2b_gap1", 64'(bus.mem_req), 64'd0);
        bus.if_req = 1'b1;
        waitMemReq("t2b_g2");
        checkOutput("t2b_addr2_fetch", 64'(bus.mem_addr), 64'h100);
        memRespond(0, 32'h2002);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        checkOutput("t2b_if_ack", 64'(bus.if_ack), 64'd1);
        step();

        // Store leaves the last load value in d_rdata
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF);
        waitMemReq("t3");
        checkOutput("t3_mem_we",    64'(bus.mem_we),    64'd1);
        checkOutput("t3_mem_addr",  64'(bus.mem_addr),  64'h40);
        checkOutput("t3_mem_wdata", 64'(bus.mem_wdata), 64'hDEAD_BEEF);
        memRespond(0, 32'h1234_5678);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        checkOutput("t3_d_ack",   64'(bus.d_ack),   64'd1);
        checkOutput("t3_d_rdata", 64'(bus.d_rdata), 64'h2001);
        step();
        checkOutput("t3_ack_pulse", 64'({bus.d_ack, bus.mem_req}), 64'd0);

        // Fetch held across its ack; address moves on the cycle after
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, '0, '0);
        waitMemReq("t4_a");
        checkOutput("t4_addr0", 64'(bus.mem_addr), 64'h0);
        memRespond(0, 32'h1111_1111);
        checkOutput("t4_ack0", 64'(bus.if_ack), 64'd1);
        step();
        checkOutput("t4_no_dup", 64'(bus.mem_req), 64'd0);
        bus.if_addr = 32'h4;
        step();
        checkOutput("t4_regrant", 64'(bus.mem_req),  64'd1);
        checkOutput("t4_addr4",   64'(bus.mem_addr), 64'h4);
        memRespond(0, 32'h2222_2222);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        checkOutput("t4_rdata", 64'(bus.if_rdata), 64'h2222_2222);
        step();
        checkOutput("t4_single", 64'(bus.mem_req), 64'd0);

        // mem_ack on the cycle the timer would expire is a normal completion
        applyStimulus(1'b1, 32'hC, 1'b0, 1'b0, '0, '0);
        waitMemReq("t5a");
        repeat (15) step();
        checkOutput("t5a_still_req", 64'(bus.mem_req), 64'd1);
        memRespond(0, 32'hAAAA_5555);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        checkOutput("t5a_if_ack",  64'(bus.if_ack),   64'd1);
        checkOutput("t5a_rdata",   64'(bus.if_rdata), 64'hAAAA_5555);
        checkOutput("t5a_bus_err", 64'(bus.bus_err),  64'd0);
        step();

        // No mem_ack at all: abort after exactly 16 mem_req cycles
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, '0, '0);
        waitMemReq("t5");
        reqCycles = 0;
        for (int i = 0; i < 40 && bus.mem_req === 1'b1; i++) begin
            reqCycles++;
            step();
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        checkOutput("t5_req_cycles", 64'(reqCycles),    64'd16);
        checkOutput("t5_if_ack",     64'(bus.if_ack),   64'd1);
        checkOutput("t5_if_rdata",   64'(bus.if_rdata), 64'd0);
        checkOutput("t5_bus_err",    64'(bus.bus_err),  64'd1);
        step();
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h44, '0);
        waitMemReq("t5_after");
        memRespond(0, 32'h5A5A_5A5A);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        checkOutput("t5_after_rdata", 64'(bus.d_rdata), 64'h5A5A_5A5A);
        checkOutput("t5_err_sticky",  64'(bus.bus_err), 64'd1);
        step();

        // Reset in the middle of a data transaction
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h80, '0);
        waitMemReq("t6");
        reset = 1'b1;
        step();
        reset = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        checkOutput("t6_mem_req", 64'(bus.mem_req), 64'd0);
        checkOutput("t6_bus_err", 64'(bus.bus_err), 64'd0);
        checkOutput("t6_d_rdata", 64'(bus.d_rdata), 64'd0);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("t6_no_ack%0d", i), 64'(bus.d_ack), 64'd0);
            step();
        end
        applyStimulus(1'b1, 32'h14, 1'b0, 1'b0, '0, '0);
        step();
        checkOutput("t6_new_grant", 64'(bus.mem_req),  64'd1);
        checkOutput("t6_new_addr",  64'(bus.mem_addr), 64'h14);
        memRespond(0, 32'h3333_3333);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        checkOutput("t6_if_ack",   64'(bus.if_ack),   64'd1);
        checkOutput("t6_if_rdata", 64'(bus.if_rdata), 64'h3333_3333);
        step();

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
